// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and constants for the data-memory arbiter
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic       P_CPU      = 1'b0;
    localparam logic       P_LDR      = 1'b1;
    localparam logic [1:0] ALIGN_MASK = 2'b00;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational two-way round-robin pick
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last,
    output logic o_gnt,
    output logic o_valid
);

    // On a tie the port that was not granted last wins; a lone request always wins.
    always_comb begin
        o_valid = i_req0 | i_req1;
        if (i_req0 && i_req1) begin
            o_gnt = ~i_last;
        end else if (i_req1) begin
            o_gnt = P_LDR;
        end else begin
            o_gnt = P_CPU;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter and sequencer for the data memory
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_LIMIT = 252,
    parameter int AW         = 32,
    parameter int DW         = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_ack,
    output logic          p0_err,
    output logic [DW-1:0] p0_rdata,
    output logic          p0_stall,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_ack,
    output logic          p1_err,
    output logic [DW-1:0] p1_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_write,
    output logic          mem_read,
    input  logic [DW-1:0] mem_rdata
);

    state_t        r_state;
    logic          r_ptr;
    logic          r_idx;
    logic          r_we;
    logic          r_err;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_rdata0;
    logic [DW-1:0] r_rdata1;

    logic          w_gnt;
    logic          w_valid;
    logic          w_req_we;
    logic [AW-1:0] w_req_addr;
    logic [DW-1:0] w_req_wdata;
    logic          w_legal;
    logic          w_access;
    logic          w_resp;

    rr_arb2 u_rr_arb2 (
        .i_req0  (p0_req),
        .i_req1  (p1_req),
        .i_last  (r_ptr),
        .o_gnt   (w_gnt),
        .o_valid (w_valid)
    );

    // Select the winner's request fields and judge the address.
    always_comb begin
        w_req_we    = (w_gnt == P_LDR) ? p1_we    : p0_we;
        w_req_addr  = (w_gnt == P_LDR) ? p1_addr  : p0_addr;
        w_req_wdata = (w_gnt == P_LDR) ? p1_wdata : p0_wdata;
        w_legal     = (w_req_addr[1:0] == ALIGN_MASK) && (w_req_addr <= AW'(ADDR_LIMIT));
    end

    // Sequencer: grant in IDLE, one memory cycle in ACCESS, ack in RESP.
    // r_addr/r_wdata drive the memory bus directly and load only on legal grants,
    // so the bus holds its last value outside ACCESS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_ptr    <= P_LDR;
            r_idx    <= P_CPU;
            r_we     <= 1'b0;
            r_err    <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_idx <= w_gnt;
                        r_ptr <= w_gnt;
                        r_we  <= w_req_we;
                        if (w_legal) begin
                            r_addr  <= w_req_addr;
                            r_wdata <= w_req_wdata;
                            r_err   <= 1'b0;
                            r_state <= ACCESS;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= RESP;
                        end
                    end
                end
                ACCESS: begin
                    if (!r_we) begin
                        if (r_idx == P_LDR) begin
                            r_rdata1 <= mem_rdata;
                        end else begin
                            r_rdata0 <= mem_rdata;
                        end
                    end
                    r_state <= RESP;
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Decode memory strobes and port responses from state; reset clears them at once.
    always_comb begin
        w_access  = (r_state == ACCESS);
        w_resp    = (r_state == RESP);
        mem_addr  = r_addr;
        mem_wdata = r_wdata;
        mem_write = w_access & r_we;
        mem_read  = w_access & ~r_we;
        p0_ack    = w_resp & (r_idx == P_CPU);
        p1_ack    = w_resp & (r_idx == P_LDR);
        p0_err    = p0_ack & r_err;
        p1_err    = p1_ack & r_err;
        p0_rdata  = r_rdata0;
        p1_rdata  = r_rdata1;
        p0_stall  = p0_req & ~p0_ack;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          p0_req, p0_we, p1_req, p1_we;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [DW-1:0] p0_wdata, p1_wdata;
    logic          p0_ack, p0_err, p0_stall, p1_ack, p1_err;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_write, mem_read;
    logic [DW-1:0] mem [0:63];

    int checks = 0;
    int errors = 0;
    vec_t vecs[11];
    int ack_port[$];
    int ack_cyc[$];

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_LIMIT(252), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata), .p0_stall(p0_stall),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
        .mem_read(mem_read), .mem_rdata(mem_rdata)
    );

    assign mem_rdata = mem[mem_addr[7:2]];
    always @(posedge clk) if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        int n_rd, n_wr, n_st, n_oth, lat, exp_lat;
        logic got, g_err;
        logic [31:0] g_rd;
        n_rd = 0; n_wr = 0; n_st = 0; n_oth = 0; lat = 0;
        got = 1'b0; g_err = 1'b0; g_rd = '0;
        @(posedge clk); #1;
        if (v.port == P_CPU) begin
            p0_we = v.we; p0_addr = v.addr; p0_wdata = v.wdata; p0_req = 1'b1;
        end else begin
            p1_we = v.we; p1_addr = v.addr; p1_wdata = v.wdata; p1_req = 1'b1;
        end
        for (int k = 1; k <= 12 && !got; k++) begin
            @(negedge clk);
            if (mem_read) n_rd++;
            if (mem_write) n_wr++;
            if (p0_stall) n_st++;
            if (v.port == P_CPU) begin
                if (p1_ack) n_oth++;
                if (p0_ack) begin got = 1'b1; lat = k - 1; g_err = p0_err; g_rd = p0_rdata; end
            end else begin
                if (p0_ack) n_oth++;
                if (p1_ack) begin got = 1'b1; lat = k - 1; g_err = p1_err; g_rd = p1_rdata; end
            end
        end
        @(posedge clk); #1;
        p0_req = 1'b0; p1_req = 1'b0;
        exp_lat = v.exp_err ? 1 : 2;
        check({tag, "_ack"}, 32'(got), 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_err"}, 32'(g_err), 32'(v.exp_err));
        if (!v.we && !v.exp_err) check({tag, "_rdata"}, g_rd, v.exp_rdata);
        check({tag, "_nread"}, 32'(n_rd), 32'((!v.we && !v.exp_err) ? 1 : 0));
        check({tag, "_nwrite"}, 32'(n_wr), 32'((v.we && !v.exp_err) ? 1 : 0));
        check({tag, "_nstall"}, 32'(n_st), 32'((v.port == P_CPU) ? exp_lat : 0));
        check({tag, "_other_ack"}, 32'(n_oth), 32'd0);
    endtask

    initial begin
        int n_p0, n_p1, n_rd;
        vecs[0]  = '{1'b0, 1'b0, 32'd4,   32'h0,        1'b0, 32'hFFFFFFFF};
        vecs[1]  = '{1'b1, 1'b1, 32'd252, 32'h11111111, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 1'b0, 32'd252, 32'h0,        1'b0, 32'h11111111};
        vecs[3]  = '{1'b0, 1'b0, 32'd6,   32'h0,        1'b1, 32'h0};
        vecs[4]  = '{1'b0, 1'b0, 32'd256, 32'h0,        1'b1, 32'h0};
        vecs[5]  = '{1'b1, 1'b1, 32'd0,   32'h12345678, 1'b0, 32'h0};
        vecs[6]  = '{1'b1, 1'b0, 32'd0,   32'h0,        1'b0, 32'h12345678};
        vecs[7]  = '{1'b0, 1'b0, 32'd0,   32'h0,        1'b0, 32'h12345678};
        vecs[8]  = '{1'b1, 1'b1, 32'd3,   32'hDEADBEEF, 1'b1, 32'h0};
        vecs[9]  = '{1'b0, 1'b0, 32'd0,   32'h0,        1'b0, 32'h12345678};
        vecs[10] = '{1'b1, 1'b0, 32'd4,   32'h0,        1'b0, 32'hFFFFFFFF};

        for (int i = 0; i < 64; i++) mem[i] = '0;
        mem[1] = 32'hFFFFFFFF;
        rst_n = 1'b0;
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;

        // Reset state
        #12;
        check("rst_p0_ack", 32'(p0_ack), 32'd0);
        check("rst_p1_ack", 32'(p1_ack), 32'd0);
        check("rst_err", 32'({p0_err, p1_err}), 32'd0);
        check("rst_mem_strobes", 32'({mem_read, mem_write}), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_p0_rdata", p0_rdata, 32'd0);
        check("rst_p1_rdata", p1_rdata, 32'd0);

        // Continuous contention from reset: grants alternate starting with p0
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'd4;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'd0;
        @(negedge clk); rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (p0_ack) begin ack_port.push_back(0); ack_cyc.push_back(k); end
            if (p1_ack) begin ack_port.push_back(1); ack_cyc.push_back(k); end
        end
        check("cont_nacks", 32'(ack_port.size()), 32'd5);
        for (int i = 0; i < 4 && i < ack_port.size(); i++)
            check($sformatf("cont_port%0d", i), 32'(ack_port[i]), 32'(i % 2));
        for (int i = 0; i < 4 && i + 1 < ack_cyc.size(); i++)
            check($sformatf("cont_gap%0d", i), 32'(ack_cyc[i+1] - ack_cyc[i]), 32'd3);
        check("cont_p0_rdata", p0_rdata, 32'hFFFFFFFF);
        rst_n = 1'b0;
        #1;
        p0_req = 1'b0; p1_req = 1'b0;
        @(negedge clk); rst_n = 1'b1;

        // Table of single-port transactions
        for (int i = 0; i < 11; i++) apply(vecs[i], $sformatf("vec%0d", i));

        // Reset during the ACCESS cycle of a p1 write
        @(posedge clk); #1;
        p1_we = 1'b1; p1_addr = 32'd8; p1_wdata = 32'hAAAAAAAA; p1_req = 1'b1;
        @(posedge clk); #1;
        check("rstmid_write_before", 32'(mem_write), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rstmid_write_dropped", 32'(mem_write), 32'd0);
        p1_req = 1'b0;
        n_p1 = 0;
        @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (p1_ack) n_p1++;
        end
        check("rstmid_no_ack", 32'(n_p1), 32'd0);
        apply('{1'b0, 1'b0, 32'd8, 32'h0, 1'b0, 32'h0}, "rstmid_read8");

        // p1 pulses req for one cycle while p0 holds the grant
        n_p0 = 0; n_p1 = 0; n_rd = 0;
        @(posedge clk); #1;
        p0_we = 1'b0; p0_addr = 32'd4; p0_req = 1'b1;
        @(posedge clk); #1;
        p1_we = 1'b0; p1_addr = 32'd0; p1_req = 1'b1;
        @(negedge clk);
        if (mem_read) n_rd++;
        @(posedge clk); #1;
        p1_req = 1'b0;
        @(negedge clk);
        if (p0_ack) n_p0++;
        if (p1_ack) n_p1++;
        check("glitch_stall_in_ack", 32'(p0_stall), 32'd0);
        @(posedge clk); #1;
        p0_req = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (p0_ack) n_p0++;
            if (p1_ack) n_p1++;
            if (mem_read) n_rd++;
        end
        check("glitch_p0_acks", 32'(n_p0), 32'd1);
        check("glitch_p1_acks", 32'(n_p1), 32'd0);
        check("glitch_reads", 32'(n_rd), 32'd1);
        check("glitch_idle", 32'(dut.r_state == IDLE), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer for the shared data memory. It shares the data memory between the pipeline MEM stage (port 0) and the program-loader/debug port (port 1). Requests are granted round-robin, and each granted access is driven onto the memory's combinational-read / posed-edge-write interface for exactly one cycle. Read data is registered and returned with a one-cycle ack pulse, and port 0 gets a stall signal until its access completes. Illegal addresses are rejected with an error response and never reach the memory.

## Interface
Parameters:
- ADDR_LIMIT, 252: highest legal word-aligned byte address (256-byte memory).
- AW, 32: address width.
- DW, 32: data width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- p0_req / p1_req  in  1  request; held high with stable fields until ack.
- p0_we / p1_we  in  1  1 = write, 0 = read.
- p0_addr / p1_addr  in  AW  byte address.
- p0_wdata / p1_wdata  in  DW  write data.
- p0_ack / p1_ack  out  1  one-cycle completion pulse.
- p0_err / p1_err  out  1  valid with ack; access rejected.
- p0_rdata / p1_rdata  out  DW  read data; valid with ack on a read, held until the next ack to that port.
- p0_stall  out  1  p0_req & ~p0_ack (combinational).
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_write  out  1  memory write enable.
- mem_read  out  1  memory read enable.
- mem_rdata  in  DW  memory combinational read data.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Any request: latch the winner's index, we, addr and wdata.
  - Legal address (addr[1:0]==0 and addr<=ADDR_LIMIT): go to ACCESS.
  - Illegal address: go to RESP with err.
- ACCESS: drive mem_* from the latched fields.
  - Read: mem_read=1; capture mem_rdata into the winner's rdata register at the end of the cycle.
  - Write: mem_write=1; the memory commits at the closing edge.
  - Always go to RESP.
- RESP: pulse ack (and err if flagged) on the winner's port, then go to IDLE.
- mem_* outputs are decoded from state and latched registers, not from the request inputs. Outside ACCESS: mem_write=0, mem_read=0; mem_addr/mem_wdata hold their last values.
- Arbitration (round-robin):
  - A 1-bit last-grant pointer, reset to 1 so port 0 wins the first tie.
  - On simultaneous requests, the port not last granted wins.
  - A lone request always wins.
  - The pointer updates on each grant, including erroring grants.
- A requester that drops req before it is granted is ignored. Dropping req after grant is a protocol violation; the access still completes.
- Port 1 has no stall; it uses ack only.

## Timing
- Reset values: state=IDLE, pointer=1; all ack, err, mem_write, mem_read = 0; rdata registers, mem_addr, mem_wdata = 0.
- Reset asserted mid-ACCESS forces mem_write=0 asynchronously, so no write commits at the following edge, and no ack is issued.
- Latency, legal access: req sampled at edge N → ACCESS during cycle N+1 → ack during cycle N+2. Ack is 2 cycles after sampling.
- Latency, illegal access: ack+err during cycle N+1.
- Throughput: one access per 3 cycles. After RESP, the FSM returns to IDLE and samples again, so a port that keeps req high after ack is treated as a new request.
- Back-to-back contention: with both ports requesting continuously, grants alternate 0,1,0,1.
- p0_stall is high from req assertion through the cycle before ack. It is low in the ack cycle, so the pipeline advances on the ack edge.

## Structure
- Package dmem_arb_pkg holds:
  - state enum {IDLE, ACCESS, RESP};
  - port-index constants P_CPU=0, P_LDR=1;
  - the alignment mask 2'b00.
- Sub-module rr_arb2 is natural: combinational two-way round-robin pick from {req0, req1, last_grant}, outputting grant index and valid.
- The top level holds the FSM, latched request registers, rdata registers and mem_* decode.

## Test plan
- Memory initialised with word@4 = FFFFFFFF. p0 reads addr 4 alone → mem_read high for 1 cycle; p0_ack 2 cycles after sampling with p0_rdata=FFFFFFFF, err=0; p0_stall high for exactly 2 cycles.
- p1 writes 11111111 @252, then p0 reads 252 → p0_rdata=11111111; exactly one mem_write cycle observed.
- p0 and p1 both request continuously from reset → grant order p0, p1, p0, p1; acks every 3 cycles, alternating ports.
- p0 reads addr 6 (misaligned), then addr 256 (out of range) → ack+err 1 cycle after sampling each time; mem_read and mem_write never asserted.
- rst_n pulled low during ACCESS of a p1 write of AAAAAAAA @8 → mem_write drops immediately; no ack; a later read @8 returns 00000000.
- p1_req asserted for 1 cycle while p0 holds the grant → p1 never acked; FSM returns to IDLE after p0's ack.
